// File: rtl/router_pkg.sv
// Shared types and helpers for the parametrised router control FSM.
package router_pkg;

   localparam int unsigned MAX_PORTS  = 16;
   localparam int unsigned MAX_ADDR_W = $clog2(MAX_PORTS);

   // Eight working states fit in 3 bits; the discard state sits apart at 4'b1000.
   typedef enum logic [3:0] {
      StDecode        = 4'd0,
      StLoadFirst     = 4'd1,
      StLoadData      = 4'd2,
      StFifoFull      = 4'd3,
      StLoadAfterFull = 4'd4,
      StLoadParity    = 4'd5,
      StCheckParity   = 4'd6,
      StWaitEmpty     = 4'd7,
      StDrop          = 4'b1000
   } state_e;

   // One-hot of an index at the widest supported port count; callers truncate.
   function automatic logic [MAX_PORTS-1:0] onehot(input logic [MAX_ADDR_W-1:0] idx);
      logic [MAX_PORTS-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/router_fsm_np_if.sv
// Handshake/control bundle between the router FSM and its FIFO/register neighbours.
interface router_fsm_np_if #(
   parameter int unsigned NUM_PORTS = 3,
   parameter int unsigned ADDR_W    = $clog2(NUM_PORTS)
);
   logic                 pkt_valid;
   logic [ADDR_W-1:0]    data_in;
   logic [NUM_PORTS-1:0] fifo_empty;
   logic                 fifo_full;
   logic [NUM_PORTS-1:0] soft_rst;
   logic                 parity_done;
   logic                 low_pkt_valid;
   logic                 busy;
   logic                 detect_add;
   logic                 lfd_state;
   logic                 ld_state;
   logic                 laf_state;
   logic                 full_state;
   logic                 write_enb_reg;
   logic                 rst_int_reg;
   logic                 drop_state;
   logic [NUM_PORTS-1:0] dest_sel;
   logic                 addr_err;
   logic                 timeout_err;

   modport master (
      output pkt_valid, data_in, fifo_empty, fifo_full, soft_rst, parity_done, low_pkt_valid,
      input  busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
             rst_int_reg, drop_state, dest_sel, addr_err, timeout_err
   );

   modport slave (
      input  pkt_valid, data_in, fifo_empty, fifo_full, soft_rst, parity_done, low_pkt_valid,
      output busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
             rst_int_reg, drop_state, dest_sel, addr_err, timeout_err
   );
endinterface

// File: rtl/router_wait_timer.sv
// Counts cycles spent waiting for the destination FIFO to drain.
module router_wait_timer #(
   parameter int unsigned WAIT_TIMEOUT = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int unsigned CntW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam logic [CntW-1:0] Last = CntW'(WAIT_TIMEOUT - 1);

   logic [CntW-1:0] cnt_q;

   // Clear dominates; the wrap after the terminal cycle is harmless since the FSM leaves.
   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   // A zero timeout never fires.
   assign tc = (WAIT_TIMEOUT != 0) && (cnt_q == Last);

endmodule

// File: rtl/router_fsm_np.sv
// Router control FSM: decodes header address and sequences FIFO loading for NUM_PORTS outputs.
module router_fsm_np
   import router_pkg::*;
#(
   parameter int unsigned NUM_PORTS    = 3,
   parameter int unsigned ADDR_W       = $clog2(NUM_PORTS),
   parameter int unsigned WAIT_TIMEOUT = 64
) (
   input logic            clk,
   input logic            rstn,
   router_fsm_np_if.slave bus
);
   state_e               state_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [NUM_PORTS-1:0] addr_oh;
   logic [NUM_PORTS-1:0] data_oh;
   logic                 addr_valid;
   logic                 dec_empty;
   logic                 empty_sel;
   logic                 soft_sel;
   logic                 wait_tc;
   logic                 timer_clr;

   // Out-of-range addresses fall off the truncated one-hot, so no bit is selected.
   assign addr_oh    = NUM_PORTS'(onehot(MAX_ADDR_W'(addr_q)));
   assign data_oh    = NUM_PORTS'(onehot(MAX_ADDR_W'(bus.data_in)));
   assign addr_valid = 32'(bus.data_in) < NUM_PORTS;
   assign dec_empty  = addr_valid && |(bus.fifo_empty & data_oh);
   assign empty_sel  = |(bus.fifo_empty & addr_oh);
   assign soft_sel   = |(bus.soft_rst & addr_oh);
   assign timer_clr  = (state_q != StWaitEmpty) || empty_sel;

   router_wait_timer #(
      .WAIT_TIMEOUT(WAIT_TIMEOUT)
   ) u_wait_timer (
      .clk (clk),
      .rstn(rstn),
      .clr (timer_clr),
      .en  (state_q == StWaitEmpty),
      .tc  (wait_tc)
   );

   // State and latched destination; soft reset of our own port overrides every transition.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= StDecode;
         addr_q  <= '0;
      end else begin
         if (state_q == StDecode && bus.pkt_valid) begin
            addr_q <= bus.data_in;
         end
         if (state_q != StDecode && soft_sel) begin
            state_q <= StDecode;
         end else begin
            case (state_q)
               StDecode: begin
                  if (bus.pkt_valid) begin
                     if (!addr_valid)    state_q <= StDrop;
                     else if (dec_empty) state_q <= StLoadFirst;
                     else                state_q <= StWaitEmpty;
                  end
               end
               StLoadFirst: state_q <= StLoadData;
               StLoadData: begin
                  if (bus.fifo_full)       state_q <= StFifoFull;
                  else if (!bus.pkt_valid) state_q <= StLoadParity;
               end
               StFifoFull: begin
                  if (!bus.fifo_full) state_q <= StLoadAfterFull;
               end
               StLoadAfterFull: begin
                  if (bus.parity_done)        state_q <= StDecode;
                  else if (bus.low_pkt_valid) state_q <= StLoadParity;
                  else                        state_q <= StLoadData;
               end
               StLoadParity: state_q <= StCheckParity;
               StCheckParity: state_q <= bus.fifo_full ? StFifoFull : StDecode;
               StWaitEmpty: begin
                  if (empty_sel)    state_q <= StLoadFirst;
                  else if (wait_tc) state_q <= StDrop;
               end
               // The parity byte (pkt_valid low) is swallowed too.
               StDrop: begin
                  if (!bus.pkt_valid) state_q <= StDecode;
               end
               default: state_q <= StDecode;
            endcase
         end
      end
   end

   // Output decodes of the current state plus the two input-qualified error pulses.
   always_comb begin
      bus.detect_add    = (state_q == StDecode);
      bus.lfd_state     = (state_q == StLoadFirst);
      bus.ld_state      = (state_q == StLoadData);
      bus.laf_state     = (state_q == StLoadAfterFull);
      bus.full_state    = (state_q == StFifoFull);
      bus.rst_int_reg   = (state_q == StCheckParity);
      bus.drop_state    = (state_q == StDrop);
      bus.busy          = (state_q == StLoadFirst) || (state_q == StFifoFull) ||
                          (state_q == StLoadAfterFull) || (state_q == StLoadParity) ||
                          (state_q == StCheckParity) || (state_q == StWaitEmpty);
      bus.write_enb_reg = (state_q == StLoadData) || (state_q == StLoadParity) ||
                          (state_q == StLoadAfterFull);
      bus.dest_sel      = '0;
      if (state_q != StDecode && state_q != StDrop) begin
         bus.dest_sel = addr_oh;
      end
      bus.addr_err      = (state_q == StDecode) && bus.pkt_valid && !addr_valid;
      bus.timeout_err   = (state_q == StWaitEmpty) && wait_tc && !empty_sel && !soft_sel;
   end

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench: vector table on a 4-port instance, hand sequences on a 3-port instance.
module tb_router_fsm_np;

   typedef enum logic [3:0] {
      ExpDecode, ExpLoadFirst, ExpLoadData, ExpFifoFull, ExpLoadAfterFull,
      ExpLoadParity, ExpCheckParity, ExpWaitEmpty, ExpDrop
   } exp_st_e;

   typedef struct {
      string      tag;
      logic       rstn;
      logic       pv;
      logic [1:0] din;
      logic [3:0] emp;
      logic       full;
      logic [3:0] srst;
      logic       pdone;
      logic       lpv;
      exp_st_e    st;
      logic [3:0] dest;
   } vec_t;

   localparam logic [3:0] E = 4'hF;

   logic clk;
   logic rstn;
   int   n_total;
   int   n_pass;
   int   wen_cnt;
   int   writes;
   int   pulses;
   vec_t vecs[$];

   router_fsm_np_if #(.NUM_PORTS(4)) if4 ();
   router_fsm_np_if #(.NUM_PORTS(3)) if3 ();

   router_fsm_np #(
      .NUM_PORTS   (4),
      .WAIT_TIMEOUT(64)
   ) dut4 (
      .clk (clk),
      .rstn(rstn),
      .bus (if4)
   );

   router_fsm_np #(
      .NUM_PORTS   (3),
      .WAIT_TIMEOUT(8)
   ) dut3 (
      .clk (clk),
      .rstn(rstn),
      .bus (if3)
   );

   always #5 clk = ~clk;

   // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int, drop} per state.
   function automatic logic [8:0] exp_bits(input exp_st_e s);
      case (s)
         ExpDecode:        return 9'b010000000;
         ExpLoadFirst:     return 9'b101000000;
         ExpLoadData:      return 9'b000100100;
         ExpFifoFull:      return 9'b100001000;
         ExpLoadAfterFull: return 9'b100010100;
         ExpLoadParity:    return 9'b100000100;
         ExpCheckParity:   return 9'b100000010;
         ExpWaitEmpty:     return 9'b100000000;
         ExpDrop:          return 9'b000000001;
         default:          return 9'b000000000;
      endcase
   endfunction

   function automatic vec_t mk(input string tag, input logic r, input logic pv,
                               input logic [1:0] din, input logic [3:0] emp, input logic full,
                               input logic [3:0] srst, input logic pdone, input logic lpv,
                               input exp_st_e st, input logic [3:0] dest);
      vec_t v;
      v.tag = tag; v.rstn = r; v.pv = pv; v.din = din; v.emp = emp; v.full = full;
      v.srst = srst; v.pdone = pdone; v.lpv = lpv; v.st = st; v.dest = dest;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive3(input logic pv, input logic [1:0] din, input logic [2:0] emp);
      @(negedge clk);
      if3.pkt_valid  = pv;
      if3.data_in    = din;
      if3.fifo_empty = emp;
      #1;
   endtask

   function automatic logic [10:0] act4();
      return {if4.busy, if4.detect_add, if4.lfd_state, if4.ld_state, if4.laf_state,
              if4.full_state, if4.write_enb_reg, if4.rst_int_reg, if4.drop_state,
              if4.addr_err, if4.timeout_err};
   endfunction

   initial begin
      clk = 1'b0; rstn = 1'b0; n_total = 0; n_pass = 0; wen_cnt = 0; writes = 0; pulses = 0;
      if4.pkt_valid = 1'b0; if4.data_in = '0; if4.fifo_empty = '1; if4.fifo_full = 1'b0;
      if4.soft_rst = '0; if4.parity_done = 1'b0; if4.low_pkt_valid = 1'b0;
      if3.pkt_valid = 1'b0; if3.data_in = '0; if3.fifo_empty = '1; if3.fifo_full = 1'b0;
      if3.soft_rst = '0; if3.parity_done = 1'b0; if3.low_pkt_valid = 1'b0;

      vecs.push_back(mk("rst", 1'b1, 1'b0, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      // Packet 1: addr 2, five LOAD_DATA cycles, no stalls.
      vecs.push_back(mk("p1_hdr", 1'b1, 1'b1, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      vecs.push_back(mk("p1_lfd", 1'b1, 1'b1, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadFirst, 4'h4));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk("p1_ld", 1'b1, 1'b1, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadData, 4'h4));
      vecs.push_back(mk("p1_ldl", 1'b1, 1'b0, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadData, 4'h4));
      vecs.push_back(mk("p1_lp", 1'b1, 1'b0, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadParity, 4'h4));
      vecs.push_back(mk("p1_cp", 1'b1, 1'b0, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpCheckParity, 4'h4));
      vecs.push_back(mk("p1_dec", 1'b1, 1'b0, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      // Packet 2: addr 0, three-cycle full stall, low_pkt_valid, then full at check parity.
      vecs.push_back(mk("p2_hdr", 1'b1, 1'b1, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      vecs.push_back(mk("p2_lfd", 1'b1, 1'b1, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadFirst, 4'h1));
      vecs.push_back(mk("p2_ld", 1'b1, 1'b1, 2'd0, E, 1'b1, 4'h0, 1'b0, 1'b0, ExpLoadData, 4'h1));
      vecs.push_back(mk("p2_f1", 1'b1, 1'b1, 2'd0, E, 1'b1, 4'h0, 1'b0, 1'b0, ExpFifoFull, 4'h1));
      vecs.push_back(mk("p2_f2", 1'b1, 1'b1, 2'd0, E, 1'b1, 4'h0, 1'b0, 1'b0, ExpFifoFull, 4'h1));
      vecs.push_back(mk("p2_f3", 1'b1, 1'b1, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpFifoFull, 4'h1));
      vecs.push_back(mk("p2_laf", 1'b1, 1'b0, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b1, ExpLoadAfterFull, 4'h1));
      vecs.push_back(mk("p2_lp", 1'b1, 1'b0, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadParity, 4'h1));
      vecs.push_back(mk("p2_cp", 1'b1, 1'b0, 2'd0, E, 1'b1, 4'h0, 1'b0, 1'b0, ExpCheckParity, 4'h1));
      vecs.push_back(mk("p2_f4", 1'b1, 1'b0, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpFifoFull, 4'h1));
      vecs.push_back(mk("p2_laf2", 1'b1, 1'b0, 2'd0, E, 1'b0, 4'h0, 1'b1, 1'b0, ExpLoadAfterFull, 4'h1));
      vecs.push_back(mk("p2_dec", 1'b1, 1'b0, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      // Packet 3: addr 3, stall then resume LOAD_DATA from LOAD_AFTER_FULL.
      vecs.push_back(mk("p3_hdr", 1'b1, 1'b1, 2'd3, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      vecs.push_back(mk("p3_lfd", 1'b1, 1'b1, 2'd3, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadFirst, 4'h8));
      vecs.push_back(mk("p3_ld", 1'b1, 1'b1, 2'd3, E, 1'b1, 4'h0, 1'b0, 1'b0, ExpLoadData, 4'h8));
      vecs.push_back(mk("p3_f", 1'b1, 1'b1, 2'd3, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpFifoFull, 4'h8));
      vecs.push_back(mk("p3_laf", 1'b1, 1'b1, 2'd3, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadAfterFull, 4'h8));
      vecs.push_back(mk("p3_ld2", 1'b1, 1'b0, 2'd3, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadData, 4'h8));
      vecs.push_back(mk("p3_lp", 1'b1, 1'b0, 2'd3, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadParity, 4'h8));
      vecs.push_back(mk("p3_cp", 1'b1, 1'b0, 2'd3, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpCheckParity, 4'h8));
      vecs.push_back(mk("p3_dec", 1'b1, 1'b0, 2'd3, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      // Packet 4: addr 1 not empty for 10 wait cycles, then empty.
      vecs.push_back(mk("p4_hdr", 1'b1, 1'b1, 2'd1, 4'hD, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk("p4_w", 1'b1, 1'b1, 2'd1, 4'hD, 1'b0, 4'h0, 1'b0, 1'b0, ExpWaitEmpty, 4'h2));
      vecs.push_back(mk("p4_we", 1'b1, 1'b1, 2'd1, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpWaitEmpty, 4'h2));
      vecs.push_back(mk("p4_lfd", 1'b1, 1'b1, 2'd1, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadFirst, 4'h2));
      vecs.push_back(mk("p4_ld", 1'b1, 1'b0, 2'd1, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadData, 4'h2));
      vecs.push_back(mk("p4_lp", 1'b1, 1'b0, 2'd1, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadParity, 4'h2));
      vecs.push_back(mk("p4_cp", 1'b1, 1'b0, 2'd1, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpCheckParity, 4'h2));
      vecs.push_back(mk("p4_dec", 1'b1, 1'b0, 2'd1, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      // Packet 5: soft reset ignored in DECODE and on other ports, honoured on addr 3.
      vecs.push_back(mk("p5_hdr", 1'b1, 1'b1, 2'd3, E, 1'b0, 4'h8, 1'b0, 1'b0, ExpDecode, 4'h0));
      vecs.push_back(mk("p5_lfd", 1'b1, 1'b1, 2'd3, E, 1'b0, 4'h7, 1'b0, 1'b0, ExpLoadFirst, 4'h8));
      vecs.push_back(mk("p5_ld", 1'b1, 1'b1, 2'd3, E, 1'b0, 4'h7, 1'b0, 1'b0, ExpLoadData, 4'h8));
      vecs.push_back(mk("p5_srst", 1'b1, 1'b1, 2'd3, E, 1'b0, 4'h8, 1'b0, 1'b0, ExpLoadData, 4'h8));
      vecs.push_back(mk("p5_dec", 1'b1, 1'b0, 2'd3, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      // Packet 6: soft reset beats the full transition.
      vecs.push_back(mk("p6_hdr", 1'b1, 1'b1, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      vecs.push_back(mk("p6_lfd", 1'b1, 1'b1, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadFirst, 4'h1));
      vecs.push_back(mk("p6_srst", 1'b1, 1'b1, 2'd0, E, 1'b1, 4'h1, 1'b0, 1'b0, ExpLoadData, 4'h1));
      vecs.push_back(mk("p6_dec", 1'b1, 1'b0, 2'd0, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      // Packet 7: hard reset mid-payload.
      vecs.push_back(mk("p7_hdr", 1'b1, 1'b1, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));
      vecs.push_back(mk("p7_lfd", 1'b1, 1'b1, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadFirst, 4'h4));
      vecs.push_back(mk("p7_rst", 1'b0, 1'b1, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpLoadData, 4'h4));
      vecs.push_back(mk("p7_dec", 1'b1, 1'b0, 2'd2, E, 1'b0, 4'h0, 1'b0, 1'b0, ExpDecode, 4'h0));

      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         rstn              = vecs[i].rstn;
         if4.pkt_valid     = vecs[i].pv;
         if4.data_in       = vecs[i].din;
         if4.fifo_empty    = vecs[i].emp;
         if4.fifo_full     = vecs[i].full;
         if4.soft_rst      = vecs[i].srst;
         if4.parity_done   = vecs[i].pdone;
         if4.low_pkt_valid = vecs[i].lpv;
         #1;
         check(vecs[i].tag, 16'(act4()), 16'({exp_bits(vecs[i].st), 2'b00}));
         check({vecs[i].tag, "_dest"}, 16'(if4.dest_sel), 16'(vecs[i].dest));
         if (vecs[i].tag.substr(0, 1) == "p1") wen_cnt += int'(if4.write_enb_reg);
      end
      check("p1_wen_cycles", 16'(wen_cnt), 16'd6);

      // Invalid address 3 on the 3-port instance: pulse, drain, no writes.
      drive3(1'b1, 2'd3, 3'b111);
      check("a_addr_err", 16'(if3.addr_err), 16'd1);
      check("a_detect", 16'(if3.detect_add), 16'd1);
      for (int i = 0; i < 3; i++) begin
         drive3(1'b1, 2'd3, 3'b111);
         check("a_drop", 16'({if3.drop_state, if3.busy, if3.addr_err}), 16'b100);
         check("a_drop_dest", 16'(if3.dest_sel), 16'd0);
         writes += int'(if3.write_enb_reg);
      end
      drive3(1'b0, 2'd3, 3'b111);
      check("a_drop_par", 16'(if3.drop_state), 16'd1);
      writes += int'(if3.write_enb_reg);
      drive3(1'b0, 2'd0, 3'b111);
      check("a_back_dec", 16'(if3.detect_add), 16'd1);
      check("a_writes", 16'(writes), 16'd0);

      // Stuck-full FIFO 1 with an 8-cycle timeout.
      drive3(1'b1, 2'd1, 3'b101);
      check("b_hdr", 16'(if3.detect_add), 16'd1);
      for (int i = 0; i < 8; i++) begin
         drive3(1'b1, 2'd1, 3'b101);
         check("b_wait_busy", 16'(if3.busy), 16'd1);
         check("b_terr", 16'(if3.timeout_err), 16'(i == 7));
         pulses += int'(if3.timeout_err);
      end
      drive3(1'b1, 2'd1, 3'b101);
      check("b_drop", 16'({if3.drop_state, if3.timeout_err}), 16'b10);
      pulses += int'(if3.timeout_err);
      drive3(1'b0, 2'd1, 3'b101);
      check("b_drop_par", 16'(if3.drop_state), 16'd1);
      drive3(1'b0, 2'd0, 3'b111);
      check("b_back_dec", 16'(if3.detect_add), 16'd1);
      check("b_pulses", 16'(pulses), 16'd1);

      // Empty arriving on the terminal wait cycle wins over the timeout.
      drive3(1'b1, 2'd1, 3'b101);
      for (int i = 0; i < 7; i++) begin
         drive3(1'b1, 2'd1, 3'b101);
         check("c_terr", 16'(if3.timeout_err), 16'd0);
      end
      drive3(1'b1, 2'd1, 3'b111);
      check("c_last", 16'({if3.busy, if3.timeout_err}), 16'b10);
      drive3(1'b1, 2'd1, 3'b111);
      check("c_lfd", 16'(if3.lfd_state), 16'd1);
      check("c_dest", 16'(if3.dest_sel), 16'b010);
      drive3(1'b0, 2'd1, 3'b111);
      check("c_ld", 16'(if3.ld_state), 16'd1);
      drive3(1'b0, 2'd1, 3'b111);
      drive3(1'b0, 2'd1, 3'b111);
      check("c_cp", 16'(if3.rst_int_reg), 16'd1);
      drive3(1'b0, 2'd0, 3'b111);
      check("c_dec", 16'(if3.detect_add), 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
